// File: rtl/voice_controller_core.sv
// Polyphonic sawtooth voice bank with a shared sample tick and a signed 24-bit mixer.
// SPI note events start, retune and stop voices; all active voices advance together.
module voice_controller_core #(
    parameter int NUM_VOICES = 16,
    parameter int SAMPLE_DIV = 1024
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_SPI_note_status,
    input  logic [7:0]  i_SPI_voice_index,
    input  logic [31:0] i_SPI_tuning_code,
    input  logic [6:0]  i_SPI_velocity,
    input  logic        i_SPI_flag,
    output logic [23:0] o_mixed_sample
);

    localparam int CW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam logic [CW-1:0] TICK_LAST = CW'(SAMPLE_DIV - 1);

    logic [CW-1:0] r_tick_cnt;
    logic          w_tick;
    logic          w_event;

    logic          r_active   [NUM_VOICES];
    logic [31:0]   r_tuning   [NUM_VOICES];
    logic [31:0]   r_phase    [NUM_VOICES];
    logic [6:0]    r_velocity [NUM_VOICES];

    logic [15:0]   w_saw [NUM_VOICES];
    logic [23:0]   w_mix;
    logic [23:0]   r_mixed_sample;
    logic          w_unused_velocity;

    assign w_tick  = (r_tick_cnt == TICK_LAST);
    assign w_event = i_SPI_flag
                   && ({24'd0, i_SPI_voice_index} < 32'(NUM_VOICES));

    // Sawtooth is the top phase half with its MSB flipped: phase[31:16] - 32768.
    always_comb begin
        for (int v = 0; v < NUM_VOICES; v++) begin
            w_saw[v] = {~r_phase[v][31], r_phase[v][30:16]};
        end
    end

    always_comb begin
        w_mix = '0;
        for (int v = 0; v < NUM_VOICES; v++) begin
            if (r_active[v]) begin
                w_mix = w_mix + {{8{w_saw[v][15]}}, w_saw[v]};
            end
        end
    end

    // Velocity is stored for future use but does not shape the audio yet.
    always_comb begin
        w_unused_velocity = 1'b0;
        for (int v = 0; v < NUM_VOICES; v++) begin
            w_unused_velocity = w_unused_velocity ^ (^r_velocity[v]);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_tick_cnt     <= '0;
            r_mixed_sample <= '0;
            for (int v = 0; v < NUM_VOICES; v++) begin
                r_active[v]   <= 1'b0;
                r_tuning[v]   <= '0;
                r_phase[v]    <= '0;
                r_velocity[v] <= '0;
            end
        end else begin
            r_tick_cnt <= w_tick ? '0 : r_tick_cnt + CW'(1);

            if (w_tick) begin
                r_mixed_sample <= w_mix;
            end

            // An event on a tick edge wins over phase advance for its voice.
            for (int v = 0; v < NUM_VOICES; v++) begin
                if (w_event && ({24'd0, i_SPI_voice_index} == 32'(v))) begin
                    r_phase[v] <= '0;
                    if (i_SPI_note_status) begin
                        r_active[v]   <= 1'b1;
                        r_tuning[v]   <= i_SPI_tuning_code;
                        r_velocity[v] <= i_SPI_velocity;
                    end else begin
                        r_active[v] <= 1'b0;
                    end
                end else if (w_tick && r_active[v]) begin
                    r_phase[v] <= r_phase[v] + r_tuning[v];
                end
            end
        end
    end

    assign o_mixed_sample = r_mixed_sample;

endmodule

// File: tb/tb_voice_controller_core.sv
// Bench for voice_controller_core: directed sawtooth scenarios plus random
// note traffic checked against a per-voice behavioural model.
module tb_voice_controller_core;

    localparam int NV  = 16;
    localparam int DIV = 128;

    logic        clk = 1'b0;
    logic        s_reset = 1'b1;
    logic        s_status = 1'b0;
    logic [7:0]  s_idx = '0;
    logic [31:0] s_tc = '0;
    logic [6:0]  s_vel = '0;
    logic        s_flag = 1'b0;
    logic [23:0] o_mix;

    int vectors = 0;
    int miscompares = 0;

    bit          m_act [NV];
    int unsigned m_tn  [NV];
    int unsigned m_ph  [NV];
    int          m_out;
    int          m_edges;
    bit          m_tick;

    voice_controller_core #(.NUM_VOICES(NV), .SAMPLE_DIV(DIV)) dut (
        .i_clk(clk),
        .i_reset(s_reset),
        .i_SPI_note_status(s_status),
        .i_SPI_voice_index(s_idx),
        .i_SPI_tuning_code(s_tc),
        .i_SPI_velocity(s_vel),
        .i_SPI_flag(s_flag),
        .o_mixed_sample(o_mix)
    );

    always #5 clk = ~clk;

    function automatic int saw(input int unsigned ph);
        return int'(ph >> 16) - 32768;
    endfunction

    // One clock edge: update the model from the inputs present at the edge.
    task automatic cycle();
        int s;
        @(posedge clk);
        m_tick = 1'b0;
        if (s_reset) begin
            for (int v = 0; v < NV; v++) begin
                m_act[v] = 1'b0;
                m_tn[v]  = 0;
                m_ph[v]  = 0;
            end
            m_out   = 0;
            m_edges = 0;
        end else begin
            m_tick = ((m_edges % DIV) == DIV - 1);
            if (m_tick) begin
                s = 0;
                for (int v = 0; v < NV; v++)
                    if (m_act[v]) s += saw(m_ph[v]);
                m_out = s;
            end
            for (int v = 0; v < NV; v++) begin
                if (s_flag && int'(s_idx) == v) begin
                    m_ph[v] = 0;
                    m_act[v] = s_status;
                    if (s_status) m_tn[v] = s_tc;
                end else if (m_tick && m_act[v]) begin
                    m_ph[v] = m_ph[v] + m_tn[v];
                end
            end
            m_edges++;
        end
        #1;
    endtask

    task automatic send(input logic st, input logic [7:0] idx,
                        input logic [31:0] tc, input logic [6:0] vel);
        s_status = st;
        s_idx    = idx;
        s_tc     = tc;
        s_vel    = vel;
        s_flag   = 1'b1;
        cycle();
        s_flag   = 1'b0;
    endtask

    task automatic wait_tick();
        do cycle(); while (!m_tick);
    endtask

    task automatic do_reset();
        s_reset = 1'b1;
        cycle();
        s_reset = 1'b0;
    endtask

    task automatic test_reset();
        s_reset = 1'b1;
        s_flag = 1'b1; s_status = 1'b1; s_idx = 8'd2; s_tc = 32'h4000_0000;
        cycle();
        cycle();
        s_reset = 1'b0;
        s_flag = 1'b0;
        vectors++;
        if (o_mix !== 24'd0) begin
            miscompares++;
            $display("FAIL reset_out: got %0d expected 0", $signed(o_mix));
        end
        for (int i = 0; i < 3 * DIV; i++) begin
            cycle();
            vectors++;
            if (o_mix !== 24'd0) begin
                miscompares++;
                $display("FAIL idle_out cyc%0d: got %0d expected 0", i, $signed(o_mix));
            end
        end
    endtask

    task automatic test_single();
        int e [3] = '{-32768, -32463, -32158};
        send(1'b1, 8'd5, 32'd20000000, 7'($urandom));
        for (int k = 0; k < 3; k++) begin
            wait_tick();
            vectors++;
            if (o_mix !== 24'(e[k])) begin
                miscompares++;
                $display("FAIL single tick%0d: got %0d expected %0d", k, $signed(o_mix), e[k]);
            end
        end
        for (int i = 0; i < DIV - 1; i++) begin
            cycle();
            vectors++;
            if (o_mix !== 24'(e[2])) begin
                miscompares++;
                $display("FAIL single_hold cyc%0d: got %0d expected %0d", i, $signed(o_mix), e[2]);
            end
        end
    endtask

    task automatic test_noteoff();
        send(1'b0, 8'd5, 32'd0, 7'd0);
        for (int k = 0; k < 2; k++) begin
            wait_tick();
            vectors++;
            if (o_mix !== 24'd0) begin
                miscompares++;
                $display("FAIL noteoff tick%0d: got %0d expected 0", k, $signed(o_mix));
            end
        end
    endtask

    task automatic test_two_voices();
        int e [2] = '{-65536, -64316};
        send(1'b1, 8'd5, 32'd20000000, 7'd64);
        send(1'b1, 8'd1, 32'd60000000, 7'd100);
        for (int k = 0; k < 2; k++) begin
            wait_tick();
            vectors++;
            if (o_mix !== 24'(e[k])) begin
                miscompares++;
                $display("FAIL two_voice tick%0d: got %0d expected %0d", k, $signed(o_mix), e[k]);
            end
        end
    endtask

    task automatic test_coincide();
        int e [3] = '{-63095, -62790, -61569};
        while ((m_edges % DIV) != DIV - 1) cycle();
        send(1'b1, 8'd5, 32'd20000000, 7'd1);
        vectors++;
        if (o_mix !== 24'(e[0]) || !m_tick) begin
            miscompares++;
            $display("FAIL coincide_edge: got %0d expected %0d", $signed(o_mix), e[0]);
        end
        for (int k = 1; k < 3; k++) begin
            wait_tick();
            vectors++;
            if (o_mix !== 24'(e[k])) begin
                miscompares++;
                $display("FAIL coincide tick%0d: got %0d expected %0d", k, $signed(o_mix), e[k]);
            end
        end
    endtask

    task automatic test_bad_index();
        send(1'b0, 8'd5, 32'd0, 7'd0);
        send(1'b0, 8'd1, 32'd0, 7'd0);
        wait_tick();
        send(1'b1, 8'd200, 32'h1234_5678, 7'd9);
        send(1'b1, 8'd16, 32'h0765_4321, 7'd9);
        for (int k = 0; k < 2; k++) begin
            wait_tick();
            vectors++;
            if (o_mix !== 24'd0) begin
                miscompares++;
                $display("FAIL bad_index tick%0d: got %0d expected 0", k, $signed(o_mix));
            end
        end
    endtask

    task automatic test_reset_midnote();
        send(1'b1, 8'd7, 32'd100000000, 7'd5);
        wait_tick();
        wait_tick();
        vectors++;
        if (o_mix !== 24'(m_out) || m_out == 0) begin
            miscompares++;
            $display("FAIL midnote_pre: got %0d expected %0d", $signed(o_mix), m_out);
        end
        repeat (5) cycle();
        do_reset();
        vectors++;
        if (o_mix !== 24'd0) begin
            miscompares++;
            $display("FAIL midnote_reset: got %0d expected 0", $signed(o_mix));
        end
        for (int k = 0; k < 2; k++) begin
            wait_tick();
            vectors++;
            if (o_mix !== 24'd0) begin
                miscompares++;
                $display("FAIL midnote_after tick%0d: got %0d expected 0", k, $signed(o_mix));
            end
        end
    endtask

    task automatic test_velocity_x();
        logic [23:0] got [2][4];
        logic [31:0] t1 = $urandom();
        logic [31:0] t2 = $urandom();
        for (int pass = 0; pass < 2; pass++) begin
            do_reset();
            send(1'b1, 8'd3, t1, pass == 0 ? 7'bx : 7'($urandom));
            send(1'b1, 8'd9, t2, pass == 0 ? 7'bx : 7'($urandom));
            s_vel = 7'bx;
            for (int k = 0; k < 4; k++) begin
                wait_tick();
                got[pass][k] = o_mix;
                vectors++;
                if (o_mix !== 24'(m_out)) begin
                    miscompares++;
                    $display("FAIL vel pass%0d tick%0d: got %0d expected %0d", pass, k, $signed(o_mix), m_out);
                end
            end
        end
        for (int k = 0; k < 4; k++) begin
            vectors++;
            if (got[0][k] !== got[1][k]) begin
                miscompares++;
                $display("FAIL vel_x_vs_driven tick%0d: got %0d expected %0d", k, $signed(got[0][k]), $signed(got[1][k]));
            end
        end
    endtask

    task automatic test_random();
        int r;
        do_reset();
        for (int i = 0; i < 5000; i++) begin
            r = $urandom_range(0, 999);
            s_reset = (r == 0);
            s_flag  = (r < 90);
            s_status = (r < 60);
            s_idx = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(16, 255))
                                                : 8'($urandom_range(0, NV - 1));
            s_tc  = $urandom();
            s_vel = 7'($urandom());
            cycle();
            vectors++;
            if (o_mix !== 24'(m_out)) begin
                miscompares++;
                $display("FAIL random cyc%0d: got %0d expected %0d", i, $signed(o_mix), m_out);
            end
        end
        s_reset = 1'b0;
        s_flag = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_noteoff();
        test_two_voices();
        test_coincide();
        test_bad_index();
        test_reset_midnote();
        test_velocity_x();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
